uart_rx: RTL



---
 rtl/xoro_pkg.sv | 27 ++
 rtl/uart_rx_fifo.sv | 47 ++++
 rtl/uart_rx.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/xoro_pkg.sv
// Shared constants for the UART receiver: register map, STATUS bit layout
// and the receive state encoding.
package xoro_pkg;

    // Register offsets; only address bit [2] distinguishes them.
    localparam logic [31:0] UART_DATA_OFS   = 32'h0000_0000;
    localparam logic [31:0] UART_STATUS_OFS = 32'h0000_0004;

    // STATUS bit positions
    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_OVERRUN   = 1;
    localparam int ST_FRAME_ERR = 2;
    localparam int ST_FULL      = 3;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // True when the decoded address bit selects the STATUS register.
    function automatic logic is_status_offset(input logic addr_bit2);
        return addr_bit2 == UART_STATUS_OFS[2];
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received characters. Pointers carry one extra wrap bit so
// full and empty fall out of a plain pointer comparison.
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic [7:0] i_din,
    input  logic       i_pop,
    output logic [7:0] o_dout,
    output logic       o_full,
    output logic       o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_push_ok;
    logic        w_pop_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_ok  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is taken.
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    // Advance read/write pointers on accepted operations.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a receive FIFO and a two-register bus slave
// (DATA pops the FIFO, STATUS reports and clears sticky errors).
module uart_rx
    import xoro_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    input  logic        serial_in
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int TW  = $clog2(DIV + 1);
    localparam logic [TW-1:0] DIV_FULL = TW'(DIV);
    localparam logic [TW-1:0] DIV_HALF = TW'(DIV / 2);

    logic            r_sync1, r_sync2;
    logic            w_line;
    rx_state_t       r_state, w_state_nxt;
    logic [TW-1:0]   r_timer, w_timer_nxt;
    logic [2:0]      r_bitcnt, w_bitcnt_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic            w_tick, w_push, w_frame_set;
    logic            r_overrun, r_frame_err;
    logic            w_full, w_empty, w_pop;
    logic [7:0]      w_head;
    logic            r_mem_ready, r_pop_pend;
    logic [31:0]     r_mem_rdata;
    logic            w_accept, w_is_status, w_is_write;
    logic [31:0]     w_status, w_rd_value;
    logic            w_ovr_set, w_ovr_clr, w_fe_clr;
    logic            w_unused;

    assign w_unused = ^{mem_instr, mem_addr[31:3], mem_addr[1:0],
                        mem_wdata[31:3], mem_wdata[0]};

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= serial_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_line = r_sync2;
    // Timer counts a loaded interval down; its last cycle is the expiry.
    assign w_tick = (r_timer <= TW'(1));

    // Receive state, bit timer and bit counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= RX_IDLE;
            r_timer  <= '0;
            r_bitcnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_bitcnt <= w_bitcnt_nxt;
        end
    end

    // Data shift register; contents only matter once a frame completes.
    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
    end

    // Receive FSM: next state, timer reloads, bit capture and stop-bit outcome.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_push       = 1'b0;
        w_frame_set  = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (!w_line) begin
                    w_state_nxt = RX_START;
                    w_timer_nxt = DIV_HALF;
                end
            end
            RX_START: begin
                if (w_tick) begin
                    if (!w_line) begin
                        w_state_nxt  = RX_DATA;
                        w_timer_nxt  = DIV_FULL;
                        w_bitcnt_nxt = '0;
                    end else begin
                        w_state_nxt = RX_IDLE;
                        w_timer_nxt = '0;
                    end
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            RX_DATA: begin
                if (w_tick) begin
                    w_shift_nxt  = {w_line, r_shift[7:1]};
                    w_timer_nxt  = DIV_FULL;
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) w_state_nxt = RX_STOP;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            RX_STOP: begin
                if (w_tick) begin
                    w_push      = w_line;
                    w_frame_set = !w_line;
                    w_state_nxt = RX_IDLE;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            default: begin
                w_state_nxt = RX_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (r_shift),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_accept    = mem_valid && enable && !r_mem_ready;
    assign w_is_status = is_status_offset(mem_addr[2]);
    assign w_is_write  = |mem_wstrb;
    // The pop decided at acceptance is performed in the acknowledge cycle.
    assign w_pop       = r_pop_pend;
    assign w_ovr_set   = w_push && w_full && !w_pop;
    assign w_ovr_clr   = w_accept && w_is_write && w_is_status && mem_wdata[1];
    assign w_fe_clr    = w_accept && w_is_write && w_is_status && mem_wdata[2];

    // Read value for the access being accepted this cycle.
    always_comb begin
        w_status               = '0;
        w_status[ST_NOT_EMPTY] = !w_empty;
        w_status[ST_OVERRUN]   = r_overrun;
        w_status[ST_FRAME_ERR] = r_frame_err;
        w_status[ST_FULL]      = w_full;
        w_rd_value             = '0;
        if (w_is_status)   w_rd_value = w_status;
        else if (!w_empty) w_rd_value = {24'b0, w_head};
    end

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_ovr_set)        r_overrun <= 1'b1;
            else if (w_ovr_clr)   r_overrun <= 1'b0;
            if (w_frame_set)      r_frame_err <= 1'b1;
            else if (w_fe_clr)    r_frame_err <= 1'b0;
        end
    end

    // Bus slave: one-cycle ack after acceptance, read data zero outside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_ready <= 1'b0;
            r_mem_rdata <= '0;
            r_pop_pend  <= 1'b0;
        end else begin
            r_mem_ready <= w_accept;
            r_mem_rdata <= (w_accept && !w_is_write) ? w_rd_value : 32'd0;
            r_pop_pend  <= w_accept && !w_is_write && !w_is_status && !w_empty;
        end
    end

    assign mem_ready = r_mem_ready;
    assign mem_rdata = r_mem_rdata;

endmodule
